vx_fetch_rob: RTL and testbench

- Next-generation instruction fetch front end. Sits between the warp scheduler and the icache, and feeds decode.
- Unlike the single-in-flight fetch, it allows up to ROB_DEPTH outstanding icache requests across warps, with a per-warp cap.
- Tolerates out-of-order icache responses and delivers fetched instructions to decode in issue order.
- Supports per-warp flush: in-flight fetches of a redirected warp are dropped silently.

---
 rtl/vx_fetch_rob_pkg.sv | 26 ++
 rtl/vx_fetch_rob_slots.sv | 75 +++++++
 rtl/vx_fetch_rob.sv | 109 ++++++++++
 tb/tb_vx_fetch_rob.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_fetch_rob_pkg.sv
// Shared sizing and slot payload type for the ROB-based fetch front end.
// Decode and the icache tag width derive from the same constants.
package vx_fetch_rob_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_THREADS  = 4;
    localparam int PC_BITS      = 30;
    localparam int UUID_WIDTH   = 1;
    localparam int WORD_BITS    = 32;
    localparam int ROB_DEPTH    = 4;
    localparam int MAX_PER_WARP = 2;

    localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int TAG_BITS  = $clog2(ROB_DEPTH);
    localparam int CNT_BITS  = $clog2(ROB_DEPTH + 1);
    localparam int WCNT_BITS = $clog2(MAX_PER_WARP + 1);

    typedef struct packed {
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [UUID_WIDTH-1:0]  uuid;
        logic [WORD_BITS-1:0]   word;
    } fetch_slot_t;

endpackage

// File: rtl/vx_fetch_rob_slots.sv
// Circular slot array with head/tail/count; fills out of order, drains in order.
// Squashed slots still wait for their response so a tag is never reused in flight.
module vx_fetch_rob_slots
    import vx_fetch_rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    input  fetch_slot_t          issue_slot,
    input  logic                 rsp_valid,
    input  logic [TAG_BITS-1:0]  rsp_tag,
    input  logic [WORD_BITS-1:0] rsp_data,
    input  logic                 flush_valid,
    input  logic [NW_BITS-1:0]   flush_wid,
    input  logic                 deq_ready,
    output logic [TAG_BITS-1:0]  tail,
    output logic [CNT_BITS-1:0]  count,
    output logic                 head_valid,
    output fetch_slot_t          head_slot,
    output logic                 retire,
    output logic [NW_BITS-1:0]   retire_wid
);

    fetch_slot_t          slot [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] done;
    logic [ROB_DEPTH-1:0] squash;
    logic [TAG_BITS-1:0]  head;
    logic                 head_done;

    assign head_done  = valid[head] && done[head];
    assign head_valid = head_done && !squash[head];
    assign head_slot  = slot[head];
    assign retire     = head_done && (squash[head] || deq_ready);
    assign retire_wid = slot[head].wid;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            done   <= '0;
            squash <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (flush_valid && valid[i] && slot[i].wid == flush_wid)
                    squash[i] <= 1'b1;
            end
            if (rsp_valid && valid[rsp_tag] && !done[rsp_tag]) begin
                done[rsp_tag]      <= 1'b1;
                slot[rsp_tag].word <= rsp_data;
            end
            if (retire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            // tail slot is always idle here, so this overrides nothing live
            if (issue) begin
                valid[tail]  <= 1'b1;
                done[tail]   <= 1'b0;
                squash[tail] <= 1'b0;
                slot[tail]   <= issue_slot;
                tail         <= tail + 1'b1;
            end
            count <= count + CNT_BITS'(issue) - CNT_BITS'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rsp_valid)
            assert (valid[rsp_tag] && !done[rsp_tag]);
    end

endmodule

// File: rtl/vx_fetch_rob.sv
// Multi-outstanding instruction fetch: scheduler handshake, per-warp caps,
// warp flush and in-order delivery to decode through the slot ROB.
module vx_fetch_rob
    import vx_fetch_rob_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sched_valid,
    input  logic [NW_BITS-1:0]     sched_wid,
    input  logic [NUM_THREADS-1:0] sched_tmask,
    input  logic [PC_BITS-1:0]     sched_pc,
    input  logic [UUID_WIDTH-1:0]  sched_uuid,
    output logic                   sched_ready,
    output logic                   icache_req_valid,
    output logic [PC_BITS-1:0]     icache_req_addr,
    output logic [TAG_BITS-1:0]    icache_req_tag,
    input  logic                   icache_req_ready,
    input  logic                   icache_rsp_valid,
    input  logic [TAG_BITS-1:0]    icache_rsp_tag,
    input  logic [WORD_BITS-1:0]   icache_rsp_data,
    output logic                   icache_rsp_ready,
    input  logic                   flush_valid,
    input  logic [NW_BITS-1:0]     flush_wid,
    output logic                   fetch_valid,
    output logic [NW_BITS-1:0]     fetch_wid,
    output logic [NUM_THREADS-1:0] fetch_tmask,
    output logic [PC_BITS-1:0]     fetch_pc,
    output logic [UUID_WIDTH-1:0]  fetch_uuid,
    output logic [WORD_BITS-1:0]   fetch_word,
    input  logic                   fetch_ready,
    output logic [NUM_WARPS-1:0]   warp_pending
);

    logic [WCNT_BITS-1:0] warp_cnt [NUM_WARPS];
    logic [NUM_WARPS-1:0] wid_inc;
    logic [NUM_WARPS-1:0] wid_dec;
    logic                 can_issue;
    logic                 issue;
    logic                 retire;
    logic                 head_valid;
    logic [TAG_BITS-1:0]  tail;
    logic [CNT_BITS-1:0]  count;
    logic [NW_BITS-1:0]   retire_wid;
    fetch_slot_t          issue_slot;
    fetch_slot_t          head_slot;

    // registered state only: a same-cycle retire does not free a slot
    assign can_issue = !reset
                    && count < CNT_BITS'(ROB_DEPTH)
                    && warp_cnt[sched_wid] < WCNT_BITS'(MAX_PER_WARP);

    assign icache_req_valid = sched_valid && can_issue;
    assign sched_ready      = icache_req_ready && can_issue;
    assign issue            = sched_valid && sched_ready;
    assign icache_req_addr  = sched_pc;
    assign icache_req_tag   = tail;
    assign icache_rsp_ready = 1'b1;

    assign issue_slot = '{wid: sched_wid, tmask: sched_tmask, pc: sched_pc,
                          uuid: sched_uuid, word: '0};

    assign fetch_valid = head_valid && !reset;
    assign fetch_wid   = head_slot.wid;
    assign fetch_tmask = head_slot.tmask;
    assign fetch_pc    = head_slot.pc;
    assign fetch_uuid  = head_slot.uuid;
    assign fetch_word  = head_slot.word;

    vx_fetch_rob_slots u_slots (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .issue_slot (issue_slot),
        .rsp_valid  (icache_rsp_valid),
        .rsp_tag    (icache_rsp_tag),
        .rsp_data   (icache_rsp_data),
        .flush_valid(flush_valid),
        .flush_wid  (flush_wid),
        .deq_ready  (fetch_ready),
        .tail       (tail),
        .count      (count),
        .head_valid (head_valid),
        .head_slot  (head_slot),
        .retire     (retire),
        .retire_wid (retire_wid)
    );

    always_comb begin
        wid_inc = '0;
        wid_dec = '0;
        if (issue)
            wid_inc[sched_wid] = 1'b1;
        if (retire)
            wid_dec[retire_wid] = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++)
            warp_pending[w] = !reset && warp_cnt[w] != '0;
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (reset)
                warp_cnt[w] <= '0;
            else
                warp_cnt[w] <= warp_cnt[w] + WCNT_BITS'(wid_inc[w])
                                           - WCNT_BITS'(wid_dec[w]);
        end
    end

endmodule

// File: tb/tb_vx_fetch_rob.sv
// Randomized bench for vx_fetch_rob: an in-order queue model of outstanding
// fetches acts as scoreboard; a negedge monitor checks and advances it.
module tb_vx_fetch_rob;
    import vx_fetch_rob_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   sched_valid;
    logic [NW_BITS-1:0]     sched_wid;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [PC_BITS-1:0]     sched_pc;
    logic [UUID_WIDTH-1:0]  sched_uuid;
    logic                   sched_ready;
    logic                   icache_req_valid;
    logic [PC_BITS-1:0]     icache_req_addr;
    logic [TAG_BITS-1:0]    icache_req_tag;
    logic                   icache_req_ready;
    logic                   icache_rsp_valid;
    logic [TAG_BITS-1:0]    icache_rsp_tag;
    logic [WORD_BITS-1:0]   icache_rsp_data;
    logic                   icache_rsp_ready;
    logic                   flush_valid;
    logic [NW_BITS-1:0]     flush_wid;
    logic                   fetch_valid;
    logic [NW_BITS-1:0]     fetch_wid;
    logic [NUM_THREADS-1:0] fetch_tmask;
    logic [PC_BITS-1:0]     fetch_pc;
    logic [UUID_WIDTH-1:0]  fetch_uuid;
    logic [WORD_BITS-1:0]   fetch_word;
    logic                   fetch_ready;
    logic [NUM_WARPS-1:0]   warp_pending;

    vx_fetch_rob dut (
        .clk(clk), .reset(reset),
        .sched_valid(sched_valid), .sched_wid(sched_wid),
        .sched_tmask(sched_tmask), .sched_pc(sched_pc),
        .sched_uuid(sched_uuid), .sched_ready(sched_ready),
        .icache_req_valid(icache_req_valid),
        .icache_req_addr(icache_req_addr),
        .icache_req_tag(icache_req_tag),
        .icache_req_ready(icache_req_ready),
        .icache_rsp_valid(icache_rsp_valid),
        .icache_rsp_tag(icache_rsp_tag),
        .icache_rsp_data(icache_rsp_data),
        .icache_rsp_ready(icache_rsp_ready),
        .flush_valid(flush_valid), .flush_wid(flush_wid),
        .fetch_valid(fetch_valid), .fetch_wid(fetch_wid),
        .fetch_tmask(fetch_tmask), .fetch_pc(fetch_pc),
        .fetch_uuid(fetch_uuid), .fetch_word(fetch_word),
        .fetch_ready(fetch_ready), .warp_pending(warp_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [UUID_WIDTH-1:0]  uuid;
        logic [WORD_BITS-1:0]   word;
        int                     tag;
        bit                     done;
        bit                     squash;
    } ent_t;

    ent_t rob[$];
    int   pend[$];
    int   checks   = 0;
    int   failures = 0;
    int   issued   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then apply this cycle's events
    always @(negedge clk) begin
        int                   wc [NUM_WARPS];
        logic [NUM_WARPS-1:0] exp_pend;
        bit                   exp_ok;
        bit                   exp_fv;
        ent_t                 e;
        if (reset) begin
            check("rst_fetch_valid", 64'(fetch_valid), 64'(0));
            check("rst_sched_ready", 64'(sched_ready), 64'(0));
            check("rst_req_valid", 64'(icache_req_valid), 64'(0));
            check("rst_warp_pending", 64'(warp_pending), 64'(0));
            rob.delete();
            pend.delete();
            issued = 0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) wc[w] = 0;
            foreach (rob[i]) wc[rob[i].wid]++;
            for (int w = 0; w < NUM_WARPS; w++) exp_pend[w] = wc[w] != 0;
            exp_ok = rob.size() < ROB_DEPTH && wc[sched_wid] < MAX_PER_WARP;
            exp_fv = rob.size() > 0 && rob[0].done && !rob[0].squash;

            check("sched_ready", 64'(sched_ready),
                  64'(icache_req_ready && exp_ok));
            check("req_valid", 64'(icache_req_valid),
                  64'(sched_valid && exp_ok));
            check("req_addr", 64'(icache_req_addr), 64'(sched_pc));
            check("rsp_ready", 64'(icache_rsp_ready), 64'(1));
            check("warp_pending", 64'(warp_pending), 64'(exp_pend));
            check("fetch_valid", 64'(fetch_valid), 64'(exp_fv));
            if (sched_valid && exp_ok)
                check("req_tag", 64'(icache_req_tag),
                      64'(issued % ROB_DEPTH));

            if (fetch_valid && fetch_ready) begin
                if (rob.size() == 0) begin
                    check("fetch_unexpected", 64'(1), 64'(0));
                end else begin
                    check("fetch_pc", 64'(fetch_pc), 64'(rob[0].pc));
                    check("fetch_word", 64'(fetch_word), 64'(rob[0].word));
                    check("fetch_meta",
                          64'({fetch_wid, fetch_tmask, fetch_uuid}),
                          64'({rob[0].wid, rob[0].tmask, rob[0].uuid}));
                end
            end

            if (rob.size() > 0 && rob[0].done &&
                (rob[0].squash || fetch_ready))
                void'(rob.pop_front());
            if (flush_valid)
                foreach (rob[i])
                    if (rob[i].wid == flush_wid) rob[i].squash = 1'b1;
            if (icache_rsp_valid)
                foreach (rob[i])
                    if (rob[i].tag == int'(icache_rsp_tag) && !rob[i].done) begin
                        rob[i].done = 1'b1;
                        rob[i].word = icache_rsp_data;
                    end
            if (sched_valid && icache_req_ready && exp_ok) begin
                e.wid    = sched_wid;
                e.tmask  = sched_tmask;
                e.pc     = sched_pc;
                e.uuid   = sched_uuid;
                e.word   = '0;
                e.tag    = issued % ROB_DEPTH;
                e.done   = 1'b0;
                e.squash = 1'b0;
                rob.push_back(e);
                pend.push_back(e.tag);
                issued++;
            end
        end
    end

    task automatic drive_rsp(input int pct);
        int idx;
        icache_rsp_valid = 1'b0;
        if (pend.size() > 0 && $urandom_range(0, 99) < pct) begin
            idx = $urandom_range(0, pend.size() - 1);
            icache_rsp_valid = 1'b1;
            icache_rsp_tag   = TAG_BITS'(pend[idx]);
            icache_rsp_data  = $urandom;
            pend.delete(idx);
        end
    endtask

    initial begin
        int phase;
        reset            = 1'b1;
        sched_valid      = 1'b0;
        sched_wid        = '0;
        sched_tmask      = '0;
        sched_pc         = '0;
        sched_uuid       = '0;
        icache_req_ready = 1'b1;
        icache_rsp_valid = 1'b0;
        icache_rsp_tag   = '0;
        icache_rsp_data  = '0;
        flush_valid      = 1'b0;
        flush_wid        = '0;
        fetch_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            phase            = (cyc / 200) % 4;
            reset            = (cyc == 1500 || cyc == 2901);
            sched_valid      = $urandom_range(0, 99) < 60;
            sched_wid        = (phase == 3) ? NW_BITS'(2) : NW_BITS'($urandom);
            sched_tmask      = NUM_THREADS'($urandom);
            sched_pc         = PC_BITS'($urandom);
            sched_uuid       = UUID_WIDTH'($urandom);
            icache_req_ready = $urandom_range(0, 99) < 85;
            fetch_ready      = (phase == 1) ? ((cyc % 50) >= 30)
                                            : ($urandom_range(0, 99) < 70);
            flush_valid      = $urandom_range(0, 99) < ((phase == 2) ? 15 : 3);
            flush_wid        = NW_BITS'($urandom);
            drive_rsp(50);
        end

        sched_valid = 1'b0;
        flush_valid = 1'b0;
        reset       = 1'b0;
        fetch_ready = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1 drive_rsp(100);
        end
        @(negedge clk);
        check("drain_pending", 64'(warp_pending), 64'(0));
        check("drain_fetch_valid", 64'(fetch_valid), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
